// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: decoder type codes, FSM states,
// access sizes and small decode helpers.
package mem_access_ctrl_pkg;

    localparam int LOAD_TYPE_BUS  = 3;
    localparam int STORE_TYPE_BUS = 3;

    typedef logic [LOAD_TYPE_BUS-1:0]  load_type_t;
    typedef logic [STORE_TYPE_BUS-1:0] store_type_t;

    localparam load_type_t LT_NONE = 3'b000;
    localparam load_type_t LT_LB   = 3'b001;
    localparam load_type_t LT_LH   = 3'b010;
    localparam load_type_t LT_LW   = 3'b011;
    localparam load_type_t LT_LD   = 3'b100;
    localparam load_type_t LT_LBU  = 3'b101;
    localparam load_type_t LT_LHU  = 3'b110;
    localparam load_type_t LT_LWU  = 3'b111;

    localparam store_type_t ST_NONE = 3'b000;
    localparam store_type_t ST_SB   = 3'b100;
    localparam store_type_t ST_SH   = 3'b101;
    localparam store_type_t ST_SW   = 3'b110;
    localparam store_type_t ST_SD   = 3'b111;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_REQ  = 2'd1,
        MEM_ST_WAIT = 2'd2,
        MEM_ST_DONE = 2'd3
    } mem_state_t;

    function automatic logic [1:0] load_size(input load_type_t lt);
        logic [1:0] s;
        case (lt)
            LT_NONE, LT_LB, LT_LBU: s = SIZE_B;
            LT_LH, LT_LHU:          s = SIZE_H;
            LT_LW, LT_LWU:          s = SIZE_W;
            LT_LD:                  s = SIZE_D;
            default:                s = SIZE_B;
        endcase
        return s;
    endfunction

    function automatic logic load_signed(input load_type_t lt);
        return (lt == LT_LB) || (lt == LT_LH) || (lt == LT_LW) || (lt == LT_LD);
    endfunction

    // Undefined store encodings fall back to their low two bits.
    function automatic logic [1:0] store_size(input store_type_t st);
        logic [1:0] s;
        case (st)
            ST_NONE: s = SIZE_B;
            ST_SB:   s = SIZE_B;
            ST_SH:   s = SIZE_H;
            ST_SW:   s = SIZE_W;
            ST_SD:   s = SIZE_D;
            default: s = st[1:0];
        endcase
        return s;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (off[0] == 1'b0);
            SIZE_W:  ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and the memory (slave).
interface mem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for the 64-bit bus: store data shift, byte enables and
// load-data extraction with sign or zero extension.
module mem_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  off,
    input  logic        sign_ext,
    input  logic [63:0] store_data,
    input  logic [63:0] bus_data,
    output logic [63:0] lane_wdata,
    output logic [7:0]  lane_mask,
    output logic [63:0] load_data
);

    logic [63:0] shifted;

    always_comb begin
        lane_wdata = store_data << {off, 3'b000};
        shifted    = bus_data >> {off, 3'b000};
        case (size)
            SIZE_B: begin
                lane_mask = 8'h01 << off;
                load_data = {{56{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                lane_mask = 8'h03 << off;
                load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                lane_mask = 8'h0F << off;
                load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                lane_mask = 8'hFF;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between EX and the data-memory bus: alignment check,
// request/response handshake, pipeline stall, timeout and load extension.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               flush,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         load_type,
    input  logic [2:0]         store_type,
    input  logic [63:0]        addr,
    input  logic [63:0]        wdata,
    output logic               stall,
    output logic               done_valid,
    output logic               done_err,
    output logic [63:0]        rdata,
    output logic               misalign,
    output logic [63:0]        bad_addr,
    mem_access_ctrl_if.master  bus
);

    mem_state_t  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next, cnt_inc;
    logic        flushed_reg, flushed_next;
    logic        err_reg, err_next;
    logic [63:0] rdata_reg, rdata_next;
    logic        misalign_reg, misalign_next;
    logic [63:0] bad_addr_reg, bad_addr_next;
    logic        bus_req_reg, bus_req_next;

    logic [1:0]  size_reg;
    logic [2:0]  off_reg;
    logic        sign_reg;
    logic        we_reg;
    logic        bus_we_reg;
    logic [63:0] bus_addr_reg;
    logic [63:0] bus_wdata_reg;
    logic [7:0]  bus_wmask_reg;

    logic        in_idle, start_req, start_ok, capture, timeout_hit, flush_seen;
    logic [1:0]  start_size;
    logic [1:0]  al_size;
    logic [2:0]  al_off;
    logic [63:0] lane_wdata, load_data;
    logic [7:0]  lane_mask;

    assign in_idle     = (state_reg == MEM_ST_IDLE);
    assign start_size  = mem_write ? store_size(store_type) : load_size(load_type);
    assign start_req   = req_valid & (mem_read | mem_write) & ~flush;
    assign start_ok    = is_aligned(start_size, addr[2:0]);
    assign cnt_inc     = cnt_reg + 16'd1;
    assign timeout_hit = (cnt_inc == 16'(TIMEOUT));

    // One lane unit serves both directions: live inputs while IDLE (store
    // steering at capture), captured access shape while waiting for read data.
    assign al_size = in_idle ? start_size : size_reg;
    assign al_off  = in_idle ? addr[2:0]  : off_reg;

    mem_align u_align (
        .size       (al_size),
        .off        (al_off),
        .sign_ext   (sign_reg),
        .store_data (wdata),
        .bus_data   (bus.bus_rdata),
        .lane_wdata (lane_wdata),
        .lane_mask  (lane_mask),
        .load_data  (load_data)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        flushed_next  = flushed_reg;
        err_next      = err_reg;
        rdata_next    = rdata_reg;
        misalign_next = 1'b0;
        bad_addr_next = bad_addr_reg;
        bus_req_next  = bus_req_reg;
        capture       = 1'b0;
        stall         = 1'b0;
        done_valid    = 1'b0;
        done_err      = 1'b0;
        flush_seen    = flushed_reg | flush;
        case (state_reg)
            MEM_ST_IDLE: begin
                if (start_req) begin
                    if (start_ok) begin
                        stall        = 1'b1;
                        capture      = 1'b1;
                        cnt_next     = 16'd0;
                        flushed_next = 1'b0;
                        err_next     = 1'b0;
                        rdata_next   = 64'd0;
                        bus_req_next = 1'b1;
                        state_next   = MEM_ST_REQ;
                    end else begin
                        misalign_next = 1'b1;
                        bad_addr_next = addr;
                    end
                end
            end
            MEM_ST_REQ: begin
                stall    = 1'b1;
                cnt_next = cnt_inc;
                if (flush && !bus.bus_ready) begin
                    bus_req_next = 1'b0;
                    state_next   = MEM_ST_IDLE;
                end else if (timeout_hit) begin
                    bus_req_next = 1'b0;
                    err_next     = 1'b1;
                    rdata_next   = 64'd0;
                    state_next   = flush ? MEM_ST_IDLE : MEM_ST_DONE;
                end else if (bus.bus_ready) begin
                    bus_req_next = 1'b0;
                    flushed_next = flush;
                    state_next   = MEM_ST_WAIT;
                end
            end
            MEM_ST_WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_inc;
                // A flushed access still drains its response so the bus stays in step.
                if (bus.bus_rvalid) begin
                    err_next   = 1'b0;
                    rdata_next = we_reg ? 64'd0 : load_data;
                    state_next = flush_seen ? MEM_ST_IDLE : MEM_ST_DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    rdata_next = 64'd0;
                    state_next = flush_seen ? MEM_ST_IDLE : MEM_ST_DONE;
                end else begin
                    flushed_next = flush_seen;
                end
            end
            MEM_ST_DONE: begin
                done_valid = ~flush;
                done_err   = err_reg & ~flush;
                state_next = MEM_ST_IDLE;
            end
            default: state_next = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= MEM_ST_IDLE;
            cnt_reg       <= 16'd0;
            flushed_reg   <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= 64'd0;
            misalign_reg  <= 1'b0;
            bad_addr_reg  <= 64'd0;
            bus_req_reg   <= 1'b0;
            size_reg      <= SIZE_B;
            off_reg       <= 3'd0;
            sign_reg      <= 1'b0;
            we_reg        <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 64'd0;
            bus_wdata_reg <= 64'd0;
            bus_wmask_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            flushed_reg   <= flushed_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            misalign_reg  <= misalign_next;
            bad_addr_reg  <= bad_addr_next;
            bus_req_reg   <= bus_req_next;
            if (capture) begin
                size_reg      <= start_size;
                off_reg       <= addr[2:0];
                sign_reg      <= ~mem_write & load_signed(load_type);
                we_reg        <= mem_write;
                bus_we_reg    <= mem_write;
                bus_addr_reg  <= {addr[63:3], 3'b000};
                bus_wdata_reg <= mem_write ? lane_wdata : 64'd0;
                bus_wmask_reg <= mem_write ? lane_mask  : 8'd0;
            end
        end
    end

    assign rdata         = rdata_reg;
    assign misalign      = misalign_reg;
    assign bad_addr      = bad_addr_reg;
    assign bus.bus_req   = bus_req_reg;
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_addr  = bus_addr_reg;
    assign bus.bus_wdata = bus_wdata_reg;
    assign bus.bus_wmask = bus_wmask_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a transaction-level timeline model
// predicts every cycle's outputs; a single negedge process compares them.
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, flush, mem_read, mem_write;
    logic [2:0]  load_type, store_type;
    logic [63:0] addr, wdata;
    logic        stall, done_valid, done_err, misalign;
    logic [63:0] rdata, bad_addr;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .flush      (flush),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .load_type  (load_type),
        .store_type (store_type),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done_valid (done_valid),
        .done_err   (done_err),
        .rdata      (rdata),
        .misalign   (misalign),
        .bad_addr   (bad_addr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle, written by the driver.
    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_done, e_err, e_mis, e_we;
    logic [63:0] e_rdata, e_bad, e_addr, e_wdata;
    logic [7:0]  e_mask;
    logic        lit_rd_en = 1'b0, lit_st_en = 1'b0;
    logic [63:0] lit_rd, lit_wd;
    logic [7:0]  lit_mask;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check1("stall", stall, e_stall);
            check1("bus_req", bus.bus_req, e_req);
            check1("done_valid", done_valid, e_done);
            check1("misalign", misalign, e_mis);
            if (e_done) begin
                check1("done_err", done_err, e_err);
                check64("rdata", rdata, e_rdata);
                if (lit_rd_en) check64("rdata_literal", rdata, lit_rd);
                $display("txn done t=%0t err=%b rdata=%h", $time, done_err, rdata);
            end
            if (e_mis) begin
                check64("bad_addr", bad_addr, e_bad);
                $display("txn misalign t=%0t bad_addr=%h", $time, bad_addr);
            end
            if (e_req) begin
                check64("bus_addr", bus.bus_addr, e_addr);
                check1("bus_we", bus.bus_we, e_we);
                if (e_we) begin
                    check64("bus_wdata", bus.bus_wdata, e_wdata);
                    check64("bus_wmask", {56'd0, bus.bus_wmask}, {56'd0, e_mask});
                end
                if (lit_st_en) begin
                    check64("bus_wdata_literal", bus.bus_wdata, lit_wd);
                    check64("bus_wmask_literal", {56'd0, bus.bus_wmask}, {56'd0, lit_mask});
                end
            end
        end
    end

    function automatic int nbytes(input logic we, input logic [2:0] ty);
        if (we) return 1 << ty[1:0];
        case (ty)
            3'b001, 3'b101: return 1;
            3'b010, 3'b110: return 2;
            3'b011, 3'b111: return 4;
            3'b100:         return 8;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] ty, input logic [63:0] a, input logic [63:0] rd);
        int          n;
        logic [63:0] v, m;
        n = nbytes(1'b0, ty);
        v = rd >> (8 * int'(a[2:0]));
        m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v = v & m;
        if ((ty == 3'b001 || ty == 3'b010 || ty == 3'b011 || ty == 3'b100) && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0; e_err = 1'b0; e_mis = 1'b0;
    endtask

    // Idle noise that never forms a start (any would-be start is flushed).
    task automatic set_idle(input logic force_rv);
        req_valid  = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        flush      = (req_valid & (mem_read | mem_write)) ? 1'b1 : 1'($urandom_range(0, 1));
        load_type  = 3'($urandom_range(0, 7));
        store_type = 3'($urandom_range(0, 7));
        addr       = {$urandom(), $urandom()};
        wdata      = {$urandom(), $urandom()};
        bus.bus_ready  = 1'($urandom_range(0, 1));
        bus.bus_rvalid = force_rv | 1'($urandom_range(0, 1));
        bus.bus_rdata  = {$urandom(), $urandom()};
        set_quiet();
    endtask

    task automatic drive_start(input logic we, input logic [2:0] ty, input logic [63:0] a, input logic [63:0] wd);
        req_valid  = 1'b1;
        flush      = 1'b0;
        mem_write  = we;
        mem_read   = we ? 1'($urandom_range(0, 1)) : 1'b1;
        load_type  = we ? 3'($urandom_range(0, 7)) : ty;
        store_type = we ? ty : 3'($urandom_range(0, 7));
        addr       = a;
        wdata      = wd;
    endtask

    // fmode: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in DONE.
    task automatic run_txn(input logic we, input logic [2:0] ty, input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd, input int d_r, input int d_v, input int fmode_in, input int fpick);
        int          n, off, ready_c, resp_c, end_c, done_t, req_end, last, fmode, f;
        logic        ok;
        logic [15:0] mm;
        n   = nbytes(we, ty);
        off = int'(a[2:0]);
        if (off % n != 0) begin
            set_idle(1'b0);
            drive_start(we, ty, a, wd);
            set_quiet();
            step();
            set_idle(1'b0);
            e_mis = 1'b1;
            e_bad = a;
            step();
            return;
        end
        ready_c = 1 + d_r;
        resp_c  = 2 + d_r + d_v;
        ok      = (resp_c <= TO);
        end_c   = ok ? resp_c : TO;
        done_t  = end_c + 1;
        req_end = (ready_c < TO) ? ready_c : TO;
        fmode   = fmode_in;
        f       = -1;
        if (fmode == 1) begin
            if (d_r >= 1) f = 1 + (fpick % d_r);
            else fmode = 0;
        end else if (fmode == 2) begin
            if (ready_c < end_c) f = ready_c + 1 + (fpick % (end_c - ready_c));
            else fmode = 0;
        end else if (fmode == 3) begin
            f = done_t;
        end
        last = (fmode == 1) ? f : ((fmode == 2) ? end_c : done_t);
        e_addr  = {a[63:3], 3'b000};
        e_we    = we;
        e_wdata = wd << (8 * off);
        mm      = ((16'd1 << n) - 16'd1) << off;
        e_mask  = mm[7:0];
        e_rdata = (!ok || we) ? 64'd0 : model_load(ty, a, rd);
        e_err   = !ok;
        for (int t = 0; t <= last; t++) begin
            if (t == 0) begin
                drive_start(we, ty, a, wd);
            end else begin
                req_valid  = 1'($urandom_range(0, 1));
                mem_read   = 1'($urandom_range(0, 1));
                mem_write  = 1'($urandom_range(0, 1));
                load_type  = 3'($urandom_range(0, 7));
                store_type = 3'($urandom_range(0, 7));
                addr       = {$urandom(), $urandom()};
                wdata      = {$urandom(), $urandom()};
                flush      = 1'b0;
            end
            if (t == f) flush = 1'b1;
            bus.bus_ready  = (t == ready_c) || ((t == 0 || t > ready_c) && ($urandom_range(0, 1) == 1));
            bus.bus_rvalid = (t == resp_c) || ((t <= ready_c || t >= done_t) && ($urandom_range(0, 1) == 1));
            bus.bus_rdata  = (t == resp_c) ? rd : {$urandom(), $urandom()};
            e_stall = (fmode == 1) ? (t <= f) : (t <= end_c);
            e_req   = (t >= 1) && (t <= ((fmode == 1) ? f : req_end));
            e_done  = (fmode == 0) && (t == done_t);
            e_mis   = 1'b0;
            step();
        end
    endtask

    task automatic idle_cycles(input int k, input logic force_rv);
        for (int i = 0; i < k; i++) begin
            set_idle(force_rv);
            step();
        end
    endtask

    initial begin
        logic        we;
        logic [2:0]  ty;
        logic [63:0] a;
        int          n, fm;

        rst = 1'b1;
        req_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        load_type = 3'd0; store_type = 3'd0; addr = 64'd0; wdata = 64'd0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 64'd0;
        set_quiet();
        #2;
        check1("reset_stall", stall, 1'b0);
        check1("reset_done_valid", done_valid, 1'b0);
        check1("reset_misalign", misalign, 1'b0);
        check1("reset_bus_req", bus.bus_req, 1'b0);
        check64("reset_rdata", rdata, 64'd0);
        check64("reset_bus_wmask", {56'd0, bus.bus_wmask}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2, 1'b0);

        lit_rd_en = 1'b1; lit_rd = 64'hFFFF_FFFF_FFFF_FF80;
        run_txn(1'b0, 3'b001, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0, 0, 0);
        lit_rd_en = 1'b0;

        lit_st_en = 1'b1; lit_wd = 64'hABCD_0000_0000_0000; lit_mask = 8'hC0;
        run_txn(1'b1, 3'b101, 64'h2006, 64'hABCD, 64'd0, 4, 0, 0, 0);
        lit_st_en = 1'b0;

        run_txn(1'b0, 3'b011, 64'h3002, 64'd0, 64'd0, 0, 0, 0, 0);
        idle_cycles(1, 1'b0);

        run_txn(1'b0, 3'b100, 64'h5000, 64'd0, 64'h1234, 0, 20, 0, 0);
        idle_cycles(3, 1'b1);

        run_txn(1'b0, 3'b111, 64'h4004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 3, 2, 0);
        lit_st_en = 1'b1; lit_wd = 64'h0123_4567_89AB_CDEF; lit_mask = 8'hFF;
        run_txn(1'b1, 3'b111, 64'h4008, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 1, 0, 0);
        lit_st_en = 1'b0;
        idle_cycles(1, 1'b0);

        // Asynchronous reset while an ld sits in WAIT.
        chk_en = 1'b0;
        drive_start(1'b0, 3'b100, 64'h6000, 64'd0);
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
        step();
        set_idle(1'b0); bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
        step();
        bus.bus_ready = 1'b0;
        check1("wait_stall_before_reset", stall, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("rst_stall", stall, 1'b0);
        check1("rst_bus_req", bus.bus_req, 1'b0);
        check1("rst_done_valid", done_valid, 1'b0);
        check64("rst_bus_addr", bus.bus_addr, 64'd0);
        check64("rst_rdata", rdata, 64'd0);
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2, 1'b1);

        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            ty = we ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 7));
            n  = nbytes(we, ty);
            a  = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'($urandom_range(0, 7) & ~(n - 1));
            fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(we, ty, a, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), fm, int'($urandom_range(0, 15)));
            idle_cycles(int'($urandom_range(0, 2)), 1'b0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
